// File: rtl/gate_tt_identifier.sv
// gate_tt_identifier
// Recovers the identity of a two-input gate by driving all four input vectors
// into it, sampling its output once each vector has settled, and decoding the
// resulting 4-bit truth table into a gate ID.
//   truth_table bit i = sampled probe_out while {probe_a,probe_b} == i
//   gate_id: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 UNKNOWN
// Every output is registered, so the gate under test sees glitch-free probes
// and done rises one cycle after the last vector is captured.
module gate_tt_identifier #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SETTLE_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       probe_a,
  output logic       probe_b,
  input  logic       probe_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_id
);

  localparam logic [2:0] ID_AND     = 3'd0;
  localparam logic [2:0] ID_OR      = 3'd1;
  localparam logic [2:0] ID_NAND    = 3'd2;
  localparam logic [2:0] ID_NOR     = 3'd3;
  localparam logic [2:0] ID_XOR     = 3'd4;
  localparam logic [2:0] ID_XNOR    = 3'd5;
  localparam logic [2:0] ID_NOT_A   = 3'd6;
  localparam logic [2:0] ID_UNKNOWN = 3'd7;

  localparam logic [SETTLE_W-1:0] CNT_RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] CNT_ONE    = SETTLE_W'(1);
  localparam logic [1:0]          IDX_LAST   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REPORT
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [1:0]          r_idx;
  logic [1:0]          w_idxNext;
  logic [SETTLE_W-1:0] r_cnt;
  logic [SETTLE_W-1:0] w_cntNext;
  logic [3:0]          r_ttShadow;
  logic [3:0]          w_ttShadowNext;
  logic [3:0]          r_truthTable;
  logic [3:0]          w_truthTableNext;
  logic [2:0]          r_gateId;
  logic [2:0]          w_gateIdNext;
  logic                r_busy;
  logic                w_busyNext;
  logic                r_done;
  logic                w_doneNext;

  // Map a captured truth table onto the gate library IDs; anything that is
  // not one of the known gates (including constant outputs) is UNKNOWN.
  function automatic logic [2:0] decodeTable(input logic [3:0] tt);
    logic [2:0] id;
    case (tt)
      4'b1000: id = ID_AND;
      4'b1110: id = ID_OR;
      4'b0111: id = ID_NAND;
      4'b0001: id = ID_NOR;
      4'b0110: id = ID_XOR;
      4'b1001: id = ID_XNOR;
      4'b0011: id = ID_NOT_A;
      default: id = ID_UNKNOWN;
    endcase
    return id;
  endfunction

  // Next-state and next-output logic: every register holds unless a state
  // below says otherwise, and done defaults low so it can only ever pulse.
  always_comb begin
    w_stateNext      = r_state;
    w_idxNext        = r_idx;
    w_cntNext        = r_cnt;
    w_ttShadowNext   = r_ttShadow;
    w_truthTableNext = r_truthTable;
    w_gateIdNext     = r_gateId;
    w_busyNext       = r_busy;
    w_doneNext       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_idxNext = 2'd0;
        if (start) begin
          w_stateNext    = ST_SETTLE;
          w_idxNext      = 2'd0;
          w_cntNext      = CNT_RELOAD;
          w_ttShadowNext = 4'b0000;
          w_busyNext     = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (r_cnt != '0) begin
          w_cntNext = r_cnt - CNT_ONE;
        end else begin
          w_ttShadowNext[r_idx] = probe_out;
          if (r_idx != IDX_LAST) begin
            w_idxNext = r_idx + 2'd1;
            w_cntNext = CNT_RELOAD;
          end else begin
            w_stateNext = ST_REPORT;
          end
        end
      end

      ST_REPORT: begin
        w_truthTableNext = r_ttShadow;
        w_gateIdNext     = decodeTable(r_ttShadow);
        w_doneNext       = 1'b1;
        w_busyNext       = 1'b0;
        w_idxNext        = 2'd0;
        w_stateNext      = ST_IDLE;
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_idxNext   = 2'd0;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over start and aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_ttShadow   <= 4'b0000;
      r_truthTable <= 4'b0000;
      r_gateId     <= ID_UNKNOWN;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_idx        <= w_idxNext;
      r_cnt        <= w_cntNext;
      r_ttShadow   <= w_ttShadowNext;
      r_truthTable <= w_truthTableNext;
      r_gateId     <= w_gateIdNext;
      r_busy       <= w_busyNext;
      r_done       <= w_doneNext;
    end
  end

  assign probe_a     = r_idx[1];
  assign probe_b     = r_idx[0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign truth_table = r_truthTable;
  assign gate_id     = r_gateId;

endmodule

// File: tb/tb_gate_tt_identifier.sv
// tb_gate_tt_identifier
// Drives gate_tt_identifier against a modelled gate under test whose output is
// an arbitrary 4-bit truth table, inverted for the first cycle after its
// inputs change, so an early sample would capture the wrong value.
module tb_gate_tt_identifier;

  localparam int S      = 2;
  localparam int RUNLEN = 4 * S + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       probeA;
  logic       probeB;
  logic       probeOut;
  logic       busy;
  logic       done;
  logic [3:0] truthTable;
  logic [2:0] gateId;

  logic [3:0] gateTable = 4'b0000;
  logic [1:0] lastVec = 2'b00;

  int nAssert = 0;
  int nFail   = 0;

  logic [3:0] expTT = 4'b0000;
  logic [2:0] expId = 3'd7;

  gate_tt_identifier #(
    .SETTLE_CYCLES(S),
    .SETTLE_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .probe_a(probeA),
    .probe_b(probeB),
    .probe_out(probeOut),
    .busy(busy),
    .done(done),
    .truth_table(truthTable),
    .gate_id(gateId)
  );

  always #5 clk = ~clk;

  // Remember the vector seen at each edge so the gate model can glitch for
  // one cycle whenever its inputs have just changed.
  always @(posedge clk) lastVec <= {probeA, probeB};

  assign probeOut = gateTable[{probeA, probeB}] ^ ({probeA, probeB} != lastVec);

  // Truth table of library gate g, built by evaluating the gate on every vector.
  function automatic logic [3:0] gateTruth(input int g);
    logic [3:0] t;
    logic a;
    logic b;
    t = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a = i[1];
      b = i[0];
      case (g)
        0: t[i] = a & b;
        1: t[i] = a | b;
        2: t[i] = ~(a & b);
        3: t[i] = ~(a | b);
        4: t[i] = a ^ b;
        5: t[i] = ~(a ^ b);
        default: t[i] = ~a;
      endcase
    end
    return t;
  endfunction

  // Reference identification: search the gate library for a matching table.
  function automatic logic [2:0] refId(input logic [3:0] tt);
    for (int g = 0; g < 7; g++) begin
      if (gateTruth(g) == tt) return 3'(g);
    end
    return 3'd7;
  endfunction

  // Count one comparison and report it if it does not hold.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    nAssert++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full identification run, optionally re-pulsing start at cycle pokeAt.
  task automatic applyStimulus(input logic [3:0] tbl, input string name, input int pokeAt);
    gateTable = tbl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput($sformatf("%s busy+0", name), 8'(busy), 8'd1);
    checkOutput($sformatf("%s probes+0", name), 8'({probeA, probeB}), 8'd0);
    for (int k = 1; k <= RUNLEN; k++) begin
      start = (k == pokeAt);
      @(posedge clk); #1;
      start = 1'b0;
      if (k < RUNLEN) begin
        checkOutput($sformatf("%s busy+%0d", name, k), 8'(busy), 8'd1);
        checkOutput($sformatf("%s done+%0d", name, k), 8'(done), 8'd0);
        checkOutput($sformatf("%s ttHold+%0d", name, k), 8'(truthTable), 8'(expTT));
        checkOutput($sformatf("%s idHold+%0d", name, k), 8'(gateId), 8'(expId));
        if (k < 4 * S)
          checkOutput($sformatf("%s probes+%0d", name, k), 8'({probeA, probeB}), 8'(k / S));
      end else begin
        expTT = tbl;
        expId = refId(tbl);
        checkOutput($sformatf("%s done", name), 8'(done), 8'd1);
        checkOutput($sformatf("%s busyLow", name), 8'(busy), 8'd0);
        checkOutput($sformatf("%s tt", name), 8'(truthTable), 8'(expTT));
        checkOutput($sformatf("%s id", name), 8'(gateId), 8'(expId));
        checkOutput($sformatf("%s probesIdle", name), 8'({probeA, probeB}), 8'd0);
      end
    end
    @(posedge clk); #1;
    checkOutput($sformatf("%s donePulse", name), 8'(done), 8'd0);
    checkOutput($sformatf("%s idleBusy", name), 8'(busy), 8'd0);
  endtask

  // Abort a run with reset at cycle rstAt and confirm nothing completes.
  task automatic applyResetMidRun(input logic [3:0] tbl, input int rstAt);
    gateTable = tbl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < rstAt; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("abort busy+%0d", k), 8'(busy), 8'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expTT = 4'b0000;
    expId = 3'd7;
    checkOutput("abort busy", 8'(busy), 8'd0);
    checkOutput("abort done", 8'(done), 8'd0);
    checkOutput("abort probes", 8'({probeA, probeB}), 8'd0);
    checkOutput("abort tt", 8'(truthTable), 8'(expTT));
    checkOutput("abort id", 8'(gateId), 8'(expId));
    for (int k = 0; k < RUNLEN + 2; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("abort noDone+%0d", k), 8'(done), 8'd0);
    end
  endtask

  // Hold start high so runs go back to back; done recurs every 4*S+2 cycles.
  task automatic applyHeldStart(input logic [3:0] tbl, input int cycles);
    logic [3:0] prevTT;
    logic [2:0] prevId;
    prevTT = expTT;
    prevId = expId;
    gateTable = tbl;
    start = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("held done@%0d", k), 8'(done),
                  8'((k % (RUNLEN + 1)) == RUNLEN));
      checkOutput($sformatf("held busy@%0d", k), 8'(busy),
                  8'((k % (RUNLEN + 1)) != RUNLEN));
      checkOutput($sformatf("held tt@%0d", k), 8'(truthTable),
                  8'((k >= RUNLEN) ? tbl : prevTT));
      checkOutput($sformatf("held id@%0d", k), 8'(gateId),
                  8'((k >= RUNLEN) ? refId(tbl) : prevId));
    end
    start = 1'b0;
    expTT = tbl;
    expId = refId(tbl);
    @(posedge clk); #1;
    checkOutput("held afterDone", 8'(done), 8'd0);
    checkOutput("held afterBusy", 8'(busy), 8'd0);
  endtask

  initial begin
    logic [3:0] rndTbl;
    int rndPoke;

    // Reset, including a start that reset must override.
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset busy", 8'(busy), 8'd0);
    checkOutput("reset done", 8'(done), 8'd0);
    checkOutput("reset probes", 8'({probeA, probeB}), 8'd0);
    checkOutput("reset tt", 8'(truthTable), 8'd0);
    checkOutput("reset id", 8'(gateId), 8'd7);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset busy", 8'(busy), 8'd0);

    // Every library gate, then constant outputs.
    applyStimulus(gateTruth(0), "AND", 0);
    applyStimulus(gateTruth(1), "OR", 0);
    applyStimulus(gateTruth(2), "NAND", 0);
    applyStimulus(gateTruth(3), "NOR", 0);
    applyStimulus(gateTruth(4), "XOR", 0);
    applyStimulus(gateTruth(5), "XNOR", 0);
    applyStimulus(gateTruth(6), "NOTA", 0);
    applyStimulus(4'b0000, "TIED0", 0);
    applyStimulus(4'b1111, "TIED1", 0);

    // start re-pulsed while busy.
    applyStimulus(gateTruth(0), "POKE3", 3);
    applyStimulus(gateTruth(4), "POKEREP", 4 * S);

    // Reset in the middle of a run, then a clean run.
    applyResetMidRun(gateTruth(1), 5);
    applyStimulus(gateTruth(2), "AFTERRST", 0);

    // Back-to-back runs with start held.
    applyHeldStart(gateTruth(0), 30);

    // Random truth tables with random re-pulses of start.
    for (int r = 0; r < 10; r++) begin
      rndTbl = 4'($urandom_range(0, 15));
      rndPoke = int'($urandom_range(0, 4 * S));
      applyStimulus(rndTbl, $sformatf("RND%0d", r), rndPoke);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  // Safety net against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
